pwm_demod: RTL and testbench

- Receive end of the team's PWM amplitude link.
- Takes a 1-bit PWM stream of nominal period FRAME_LEN clocks, measures the high time of each frame, and recovers the signed 8-bit amplitude the modulator encoded.
- Sits between the PWM pin/loopback and downstream sample consumers (BPSK demod datapath, scope/debug capture).
- Emits one amplitude sample per frame with a valid strobe, plus lock/sync status.

---
 rtl/pwm_pkg.sv | 29 ++
 rtl/input_sync.sv | 30 +++
 rtl/pwm_demod.sv | 133 +++++++++++++
 tb/tb_pwm_demod.sv | 375 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pwm_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pwm_pkg
// Description : Shared types, constants and amplitude scaling for the PWM link.
// Revision    : 1.0 - initial release
// ============================================================================
package pwm_pkg;

    localparam int AMP_W             = 8;
    localparam int DEFAULT_FRAME_LEN = 16;

    typedef enum logic [0:0] {
        SEARCH  = 1'b0,
        MEASURE = 1'b1
    } state_t;

    // floor(high*255/2^log2_len) - 128; the 17-bit product covers the largest
    // legal frame (256 clocks), and subtracting 128 is a flip of the MSB.
    function automatic logic signed [AMP_W-1:0] amp_from_high(input logic [8:0] high,
                                                              input int         log2_len);
        logic [16:0] prod;
        logic [7:0]  scaled;
        prod   = 17'(high) * 17'd255;
        scaled = 8'(prod >> log2_len);
        return {~scaled[7], scaled[6:0]};
    endfunction

endpackage
`default_nettype wire

// File: rtl/input_sync.sv
`default_nettype none
// ============================================================================
// Module      : input_sync
// Description : Two-flop synchronizer for a single asynchronous input bit.
// Revision    : 1.0 - initial release
// ============================================================================
module input_sync (
    input  logic clock,
    input  logic reset_n,
    input  logic i_async,
    output logic o_sync
);

    logic r_meta;
    logic r_sync;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_meta <= 1'b0;
            r_sync <= 1'b0;
        end else begin
            r_meta <= i_async;
            r_sync <= r_meta;
        end
    end

    assign o_sync = r_sync;

endmodule
`default_nettype wire

// File: rtl/pwm_demod.sv
`default_nettype none
// ============================================================================
// Module      : pwm_demod
// Description : Recovers a signed amplitude per PWM frame from measured high time.
// Revision    : 1.0 - initial release
// ============================================================================
module pwm_demod
    import pwm_pkg::*;
#(
    parameter int FRAME_LEN   = DEFAULT_FRAME_LEN,
    parameter int MISS_FRAMES = 4
) (
    input  logic                    clock,
    input  logic                    reset_n,
    input  logic                    pwm_in,
    output logic signed [AMP_W-1:0] amp,
    output logic                    amp_valid,
    output logic                    locked,
    output logic                    sync_err
);

    localparam int c_CNT_W  = $clog2(FRAME_LEN);
    localparam int c_HIGH_W = c_CNT_W + 1;
    localparam int c_MISS_W = $clog2(MISS_FRAMES + 1);

    localparam logic [c_CNT_W-1:0]  c_LAST     = c_CNT_W'(FRAME_LEN - 1);
    localparam logic [c_MISS_W-1:0] c_MISS_MAX = c_MISS_W'(MISS_FRAMES);

    if (FRAME_LEN < 4 || FRAME_LEN > 256 || (FRAME_LEN & (FRAME_LEN - 1)) != 0
        || MISS_FRAMES < 1) begin : g_bad_params
        $error("pwm_demod: FRAME_LEN must be a power of two in 4..256, MISS_FRAMES >= 1");
    end

    state_t                    r_state;
    logic                      r_prev;
    logic [c_CNT_W-1:0]        r_frame_cnt;
    logic [c_HIGH_W-1:0]       r_high_cnt;
    logic [c_MISS_W-1:0]       r_miss_cnt;
    logic                      r_edge_seen;
    logic signed [AMP_W-1:0]   r_amp;
    logic                      r_amp_valid;
    logic                      r_locked;
    logic                      r_sync_err;

    logic                      w_sync;
    logic                      w_rise;
    logic                      w_frame_end;
    logic [c_HIGH_W-1:0]       w_high_total;

    input_sync u_input_sync (
        .clock   (clock),
        .reset_n (reset_n),
        .i_async (pwm_in),
        .o_sync  (w_sync)
    );

    // r_frame_cnt is the index of the sample being taken this cycle;
    // r_high_cnt is the high count accumulated before it.
    assign w_rise       = w_sync & ~r_prev;
    assign w_frame_end  = (r_frame_cnt == c_LAST);
    assign w_high_total = r_high_cnt + c_HIGH_W'(w_sync);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= SEARCH;
            r_prev      <= 1'b0;
            r_frame_cnt <= '0;
            r_high_cnt  <= '0;
            r_miss_cnt  <= '0;
            r_edge_seen <= 1'b0;
            r_amp       <= -8'sd128;
            r_amp_valid <= 1'b0;
            r_locked    <= 1'b0;
            r_sync_err  <= 1'b0;
        end else begin
            r_prev      <= w_sync;
            r_amp_valid <= 1'b0;
            r_sync_err  <= 1'b0;
            r_locked    <= (r_state == MEASURE) && (r_miss_cnt < c_MISS_MAX);

            case (r_state)
                SEARCH: begin
                    if (w_rise) begin
                        r_state     <= MEASURE;
                        r_frame_cnt <= c_CNT_W'(1);
                        r_high_cnt  <= c_HIGH_W'(1);
                        r_miss_cnt  <= '0;
                        r_edge_seen <= 1'b1;
                    end
                end
                MEASURE: begin
                    if (w_rise && r_frame_cnt != '0) begin
                        // Misaligned edge (including on the last sample): drop
                        // the partial frame and restart on this sample.
                        r_sync_err  <= 1'b1;
                        r_frame_cnt <= c_CNT_W'(1);
                        r_high_cnt  <= c_HIGH_W'(1);
                        r_miss_cnt  <= '0;
                        r_edge_seen <= 1'b1;
                    end else begin
                        r_frame_cnt <= r_frame_cnt + 1'b1;
                        if (w_frame_end) begin
                            r_amp       <= amp_from_high(9'(w_high_total), c_CNT_W);
                            r_amp_valid <= 1'b1;
                            r_high_cnt  <= '0;
                            r_edge_seen <= 1'b0;
                            if (!r_edge_seen && r_miss_cnt < c_MISS_MAX) begin
                                r_miss_cnt <= r_miss_cnt + 1'b1;
                            end
                        end else begin
                            r_high_cnt <= w_high_total;
                            if (w_rise) begin
                                r_miss_cnt  <= '0;
                                r_edge_seen <= 1'b1;
                            end
                        end
                    end
                end
                default: r_state <= SEARCH;
            endcase
        end
    end

    a_high_range: assert property (@(posedge clock) disable iff (!reset_n)
        !(r_state == MEASURE && w_frame_end) || (w_high_total <= c_HIGH_W'(FRAME_LEN)));

    assign amp       = r_amp;
    assign amp_valid = r_amp_valid;
    assign locked    = r_locked;
    assign sync_err  = r_sync_err;

endmodule
`default_nettype wire

// File: tb/tb_pwm_demod.sv
`default_nettype none
// ============================================================================
// Module      : tb_pwm_demod
// Description : Randomized and directed self-checking bench for pwm_demod.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pwm_demod;

    localparam int F    = 16;
    localparam int MISS = 4;
    localparam int MAXN = 400;

    logic              clock = 1'b0;
    logic              reset_n = 1'b0;
    logic              pwm_in = 1'b0;
    logic signed [7:0] amp;
    logic              amp_valid;
    logic              locked;
    logic              sync_err;

    int n_tests = 0;
    int n_fail  = 0;
    int wp      = 0;

    bit                b     [MAXN];
    logic              obs_v [MAXN];
    logic              obs_e [MAXN];
    logic              obs_l [MAXN];
    logic signed [7:0] obs_a [MAXN];
    logic              exp_v [MAXN];
    logic              exp_e [MAXN];
    logic              exp_l [MAXN];
    logic signed [7:0] exp_a [MAXN];

    pwm_demod #(.FRAME_LEN(F), .MISS_FRAMES(MISS)) dut (
        .clock     (clock),
        .reset_n   (reset_n),
        .pwm_in    (pwm_in),
        .amp       (amp),
        .amp_valid (amp_valid),
        .locked    (locked),
        .sync_err  (sync_err)
    );

    always #5 clock = ~clock;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic clear_pattern();
        wp = 0;
        for (int i = 0; i < MAXN; i++) b[i] = 1'b0;
    endtask

    task automatic add(input bit level, input int count);
        for (int i = 0; i < count; i++) begin
            if (wp < MAXN) b[wp] = level;
            wp++;
        end
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        pwm_in  = 1'b0;
        repeat (3) @(posedge clock);
        @(negedge clock);
        reset_n = 1'b1;
    endtask

    // Sample i is presented before posedge i; outputs are recorded 1ns after it.
    task automatic run_pattern(input int n);
        for (int i = 0; i < n; i++) begin
            pwm_in = b[i];
            @(posedge clock);
            #1;
            obs_v[i] = amp_valid;
            obs_e[i] = sync_err;
            obs_l[i] = locked;
            obs_a[i] = amp;
        end
    endtask

    function automatic bit is_rise(input int i);
        return b[i] && (i == 0 || !b[i-1]);
    endfunction

    // Frame-level reference: walk the sample stream frame by frame, look for
    // edges inside each window, and place expected outputs 2 cycles after the
    // sample that triggers them (synchronizer plus output register).
    task automatic build_model(input int n);
        int r0, st, m, fin, hi, miss, cur_miss;
        int miss_ev [MAXN];
        int val_at  [MAXN];
        logic signed [7:0] cur_amp;
        for (int k = 0; k < MAXN; k++) begin
            exp_v[k] = 1'b0; exp_e[k] = 1'b0; miss_ev[k] = -1; val_at[k] = 0;
        end
        r0 = -1;
        for (int i = 0; i < n; i++) if (is_rise(i)) begin r0 = i; break; end
        miss = 0;
        if (r0 >= 0) begin
            st = r0;
            while (st < n) begin
                m = -1;
                for (int j = st + 1; j < st + F && j < n; j++)
                    if (is_rise(j)) begin m = j; break; end
                if (m >= 0) begin
                    if (m + 2 < n) begin exp_e[m+2] = 1'b1; miss_ev[m+2] = 0; end
                    miss = 0;
                    st = m;
                end else begin
                    fin = st + F - 1;
                    if (fin >= n) break;
                    hi = 0;
                    for (int j = st; j <= fin; j++) hi += int'(b[j]);
                    if (!is_rise(st)) miss = (miss < MISS) ? miss + 1 : MISS;
                    if (fin + 2 < n) begin
                        exp_v[fin+2]   = 1'b1;
                        val_at[fin+2]  = (hi * 255) / F - 128;
                        miss_ev[fin+2] = miss;
                    end
                    st = fin + 1;
                    if (st < n && is_rise(st)) begin
                        miss = 0;
                        if (st + 2 < n) miss_ev[st+2] = 0;
                    end
                end
            end
        end
        cur_miss = 0;
        cur_amp  = -8'sd128;
        for (int k = 0; k < MAXN; k++) begin
            exp_l[k] = (k > 0) && (r0 >= 0) && (k - 1 >= r0 + 2) && (cur_miss < MISS);
            if (miss_ev[k] >= 0) cur_miss = miss_ev[k];
            if (exp_v[k]) cur_amp = 8'(val_at[k]);
            exp_a[k] = cur_amp;
        end
    endtask

    task automatic test_reset();
        pwm_in = 1'b1;
        repeat (2) @(posedge clock);
        #1;
        n_tests += 4;
        if (amp !== -8'sd128) begin n_fail++; $display("FAIL reset/amp got %0d exp -128", amp); end
        if (amp_valid !== 1'b0) begin n_fail++; $display("FAIL reset/amp_valid got %b exp 0", amp_valid); end
        if (locked !== 1'b0) begin n_fail++; $display("FAIL reset/locked got %b exp 0", locked); end
        if (sync_err !== 1'b0) begin n_fail++; $display("FAIL reset/sync_err got %b exp 0", sync_err); end
    endtask

    task automatic test_amp_zero();
        int n, nv;
        do_reset();
        clear_pattern();
        add(0, 5);
        repeat (10) begin add(1, 8); add(0, 8); end
        n = wp + 4;
        run_pattern(n);
        build_model(n);
        nv = 0;
        for (int k = 0; k < n; k++) begin
            n_tests += 4;
            if (obs_v[k] !== exp_v[k]) begin n_fail++; $display("FAIL zero/valid cyc %0d got %b exp %b", k, obs_v[k], exp_v[k]); end
            if (obs_e[k] !== exp_e[k]) begin n_fail++; $display("FAIL zero/sync_err cyc %0d got %b exp %b", k, obs_e[k], exp_e[k]); end
            if (obs_l[k] !== exp_l[k]) begin n_fail++; $display("FAIL zero/locked cyc %0d got %b exp %b", k, obs_l[k], exp_l[k]); end
            if (obs_a[k] !== exp_a[k]) begin n_fail++; $display("FAIL zero/amp cyc %0d got %0d exp %0d", k, obs_a[k], exp_a[k]); end
            if (obs_v[k] === 1'b1) begin
                nv++;
                n_tests++;
                if (obs_a[k] !== -8'sd1) begin n_fail++; $display("FAIL zero/amp_value cyc %0d got %0d exp -1", k, obs_a[k]); end
            end
        end
        n_tests++;
        if (nv != 10) begin n_fail++; $display("FAIL zero/valid_count got %0d exp 10", nv); end
    endtask

    task automatic test_amp_switch();
        int n, nv, last;
        logic signed [7:0] want;
        do_reset();
        clear_pattern();
        add(0, 5);
        repeat (6) begin add(1, 12); add(0, 4); end
        repeat (6) begin add(1, 4); add(0, 12); end
        n = wp + 4;
        run_pattern(n);
        build_model(n);
        nv = 0;
        last = -1;
        for (int k = 0; k < n; k++) begin
            n_tests += 4;
            if (obs_v[k] !== exp_v[k]) begin n_fail++; $display("FAIL switch/valid cyc %0d got %b exp %b", k, obs_v[k], exp_v[k]); end
            if (obs_e[k] !== exp_e[k]) begin n_fail++; $display("FAIL switch/sync_err cyc %0d got %b exp %b", k, obs_e[k], exp_e[k]); end
            if (obs_l[k] !== exp_l[k]) begin n_fail++; $display("FAIL switch/locked cyc %0d got %b exp %b", k, obs_l[k], exp_l[k]); end
            if (obs_a[k] !== exp_a[k]) begin n_fail++; $display("FAIL switch/amp cyc %0d got %0d exp %0d", k, obs_a[k], exp_a[k]); end
            if (obs_v[k] === 1'b1) begin
                want = (nv < 6) ? 8'sd63 : -8'sd65;
                n_tests++;
                if (obs_a[k] !== want) begin n_fail++; $display("FAIL switch/amp_value frame %0d got %0d exp %0d", nv, obs_a[k], want); end
                if (last >= 0) begin
                    n_tests++;
                    if (k - last != F) begin n_fail++; $display("FAIL switch/valid_gap cyc %0d got %0d exp %0d", k, k - last, F); end
                end
                last = k;
                nv++;
            end
        end
        n_tests++;
        if (nv != 12) begin n_fail++; $display("FAIL switch/valid_count got %0d exp 12", nv); end
    endtask

    task automatic test_stuck_low();
        int n;
        do_reset();
        clear_pattern();
        n = 200;
        run_pattern(n);
        build_model(n);
        for (int k = 0; k < n; k++) begin
            n_tests += 4;
            if (obs_v[k] !== 1'b0) begin n_fail++; $display("FAIL low/valid cyc %0d got %b exp 0", k, obs_v[k]); end
            if (obs_e[k] !== exp_e[k]) begin n_fail++; $display("FAIL low/sync_err cyc %0d got %b exp %b", k, obs_e[k], exp_e[k]); end
            if (obs_l[k] !== 1'b0) begin n_fail++; $display("FAIL low/locked cyc %0d got %b exp 0", k, obs_l[k]); end
            if (obs_a[k] !== -8'sd128) begin n_fail++; $display("FAIL low/amp cyc %0d got %0d exp -128", k, obs_a[k]); end
        end
    endtask

    task automatic test_stuck_high();
        int n, nv;
        do_reset();
        clear_pattern();
        add(0, 3);
        add(1, 16 * 8);
        n = wp + 4;
        run_pattern(n);
        build_model(n);
        nv = 0;
        for (int k = 0; k < n; k++) begin
            n_tests += 4;
            if (obs_v[k] !== exp_v[k]) begin n_fail++; $display("FAIL high/valid cyc %0d got %b exp %b", k, obs_v[k], exp_v[k]); end
            if (obs_e[k] !== exp_e[k]) begin n_fail++; $display("FAIL high/sync_err cyc %0d got %b exp %b", k, obs_e[k], exp_e[k]); end
            if (obs_l[k] !== exp_l[k]) begin n_fail++; $display("FAIL high/locked cyc %0d got %b exp %b", k, obs_l[k], exp_l[k]); end
            if (obs_a[k] !== exp_a[k]) begin n_fail++; $display("FAIL high/amp cyc %0d got %0d exp %0d", k, obs_a[k], exp_a[k]); end
            if (obs_v[k] === 1'b1) begin
                nv++;
                n_tests++;
                if (obs_a[k] !== 8'sd127) begin n_fail++; $display("FAIL high/amp_value cyc %0d got %0d exp 127", k, obs_a[k]); end
            end
        end
        n_tests += 2;
        if (nv != 8) begin n_fail++; $display("FAIL high/valid_count got %0d exp 8", nv); end
        if (obs_l[n-1] !== 1'b0) begin n_fail++; $display("FAIL high/lock_lost got %b exp 0", obs_l[n-1]); end
    endtask

    task automatic test_misaligned();
        int n, e1, e2, ne;
        do_reset();
        clear_pattern();
        add(0, 4);
        repeat (2) begin add(1, 8); add(0, 8); end
        add(1, 3); add(0, 4);
        e1 = wp + 2;
        repeat (2) begin add(1, 8); add(0, 8); end
        add(1, 8); add(0, 7);
        e2 = wp + 2;
        repeat (2) begin add(1, 8); add(0, 8); end
        n = wp + 4;
        run_pattern(n);
        build_model(n);
        ne = 0;
        for (int k = 0; k < n; k++) begin
            n_tests += 4;
            if (obs_v[k] !== exp_v[k]) begin n_fail++; $display("FAIL misalign/valid cyc %0d got %b exp %b", k, obs_v[k], exp_v[k]); end
            if (obs_e[k] !== exp_e[k]) begin n_fail++; $display("FAIL misalign/sync_err cyc %0d got %b exp %b", k, obs_e[k], exp_e[k]); end
            if (obs_l[k] !== exp_l[k]) begin n_fail++; $display("FAIL misalign/locked cyc %0d got %b exp %b", k, obs_l[k], exp_l[k]); end
            if (obs_a[k] !== exp_a[k]) begin n_fail++; $display("FAIL misalign/amp cyc %0d got %0d exp %0d", k, obs_a[k], exp_a[k]); end
            if (obs_e[k] === 1'b1) ne++;
        end
        n_tests += 7;
        if (ne != 2) begin n_fail++; $display("FAIL misalign/err_count got %0d exp 2", ne); end
        if (obs_e[e1] !== 1'b1) begin n_fail++; $display("FAIL misalign/err_mid cyc %0d got %b exp 1", e1, obs_e[e1]); end
        if (obs_e[e2] !== 1'b1) begin n_fail++; $display("FAIL misalign/err_last cyc %0d got %b exp 1", e2, obs_e[e2]); end
        if (obs_v[e2] !== 1'b0) begin n_fail++; $display("FAIL misalign/no_valid_last got %b exp 0", obs_v[e2]); end
        if (obs_v[e1+15] !== 1'b1 || obs_a[e1+15] !== -8'sd1) begin
            n_fail++; $display("FAIL misalign/resync_mid valid %b amp %0d exp 1 -1", obs_v[e1+15], obs_a[e1+15]);
        end
        if (obs_v[e2+15] !== 1'b1 || obs_a[e2+15] !== -8'sd1) begin
            n_fail++; $display("FAIL misalign/resync_last valid %b amp %0d exp 1 -1", obs_v[e2+15], obs_a[e2+15]);
        end
        if (obs_e[e1+1] !== 1'b0) begin n_fail++; $display("FAIL misalign/err_width got %b exp 0", obs_e[e1+1]); end
    endtask

    task automatic test_reset_mid_frame();
        int n;
        do_reset();
        clear_pattern();
        add(0, 2);
        repeat (4) begin add(1, 8); add(0, 8); end
        run_pattern(46);
        n_tests += 2;
        if (obs_l[45] !== 1'b1) begin n_fail++; $display("FAIL rstmid/locked_before got %b exp 1", obs_l[45]); end
        if (obs_a[45] !== -8'sd1) begin n_fail++; $display("FAIL rstmid/amp_before got %0d exp -1", obs_a[45]); end
        #1;
        reset_n = 1'b0;
        #1;
        n_tests += 4;
        if (amp !== -8'sd128) begin n_fail++; $display("FAIL rstmid/amp got %0d exp -128", amp); end
        if (amp_valid !== 1'b0) begin n_fail++; $display("FAIL rstmid/amp_valid got %b exp 0", amp_valid); end
        if (locked !== 1'b0) begin n_fail++; $display("FAIL rstmid/locked got %b exp 0", locked); end
        if (sync_err !== 1'b0) begin n_fail++; $display("FAIL rstmid/sync_err got %b exp 0", sync_err); end
        repeat (3) @(posedge clock);
        @(negedge clock);
        reset_n = 1'b1;
        clear_pattern();
        add(0, 3);
        repeat (3) begin add(1, 5); add(0, 11); end
        n = wp + 4;
        run_pattern(n);
        build_model(n);
        for (int k = 0; k < n; k++) begin
            n_tests += 4;
            if (obs_v[k] !== exp_v[k]) begin n_fail++; $display("FAIL rstmid/valid cyc %0d got %b exp %b", k, obs_v[k], exp_v[k]); end
            if (obs_e[k] !== exp_e[k]) begin n_fail++; $display("FAIL rstmid/sync_err cyc %0d got %b exp %b", k, obs_e[k], exp_e[k]); end
            if (obs_l[k] !== exp_l[k]) begin n_fail++; $display("FAIL rstmid/locked cyc %0d got %b exp %b", k, obs_l[k], exp_l[k]); end
            if (obs_a[k] !== exp_a[k]) begin n_fail++; $display("FAIL rstmid/amp cyc %0d got %0d exp %0d", k, obs_a[k], exp_a[k]); end
        end
    endtask

    task automatic test_random();
        int n, h;
        for (int iter = 0; iter < 3; iter++) begin
            do_reset();
            clear_pattern();
            add(0, int'($urandom_range(0, 20)));
            while (wp < 330) begin
                if ($urandom_range(0, 9) == 0) begin
                    add(0, int'($urandom_range(1, 5)));
                    add(1, int'($urandom_range(1, 6)));
                end else begin
                    h = int'($urandom_range(0, F));
                    add(1, h);
                    add(0, F - h);
                end
            end
            n = (wp + 4 < MAXN) ? wp + 4 : MAXN;
            run_pattern(n);
            build_model(n);
            for (int k = 0; k < n; k++) begin
                n_tests += 4;
                if (obs_v[k] !== exp_v[k]) begin n_fail++; $display("FAIL rand%0d/valid cyc %0d got %b exp %b", iter, k, obs_v[k], exp_v[k]); end
                if (obs_e[k] !== exp_e[k]) begin n_fail++; $display("FAIL rand%0d/sync_err cyc %0d got %b exp %b", iter, k, obs_e[k], exp_e[k]); end
                if (obs_l[k] !== exp_l[k]) begin n_fail++; $display("FAIL rand%0d/locked cyc %0d got %b exp %b", iter, k, obs_l[k], exp_l[k]); end
                if (obs_a[k] !== exp_a[k]) begin n_fail++; $display("FAIL rand%0d/amp cyc %0d got %0d exp %0d", iter, k, obs_a[k], exp_a[k]); end
            end
        end
    endtask

    initial begin
        test_reset();
        test_amp_zero();
        test_amp_switch();
        test_stuck_low();
        test_stuck_high();
        test_misaligned();
        test_reset_mid_frame();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
